// File: rtl/sum_accumulator.sv
// Accumulates SAMPLES accepted sum bytes into a 16-bit total, then streams the
// total out as two bytes (low, then high) with a per-window overflow flag.
module sum_accumulator #(
  parameter int SAMPLES = 4,
  parameter bit SAT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_ovf
);

  localparam int CW = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    EMIT_LO = 2'd1,
    EMIT_HI = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   acc;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic [7:0]    res_hi;

  logic [16:0]   sum17;
  logic [15:0]   acc_next;
  logic          last_beat;

  assign sum17     = {1'b0, acc} + {9'd0, in_data};
  assign acc_next  = (SAT && sum17[16]) ? 16'hFFFF : sum17[15:0];
  assign last_beat = (cnt == CW'(SAMPLES - 1));

  // The low result byte is loaded straight into out_data on the closing
  // input beat, so only the high byte needs to be kept for the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      res_hi    <= '0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            if (last_beat) begin
              res_hi    <= acc_next[15:8];
              out_data  <= acc_next[7:0];
              out_ovf   <= ovf_acc | sum17[16];
              out_last  <= 1'b0;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
              ovf_acc   <= 1'b0;
              state     <= EMIT_LO;
            end else begin
              acc     <= acc_next;
              cnt     <= cnt + 1'b1;
              ovf_acc <= ovf_acc | sum17[16];
            end
          end
        end
        EMIT_LO: begin
          if (out_ready) begin
            out_data <= res_hi;
            out_last <= 1'b1;
            state    <= EMIT_HI;
          end
        end
        EMIT_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_ovf   <= 1'b0;
          in_ready  <= 1'b0;
          state     <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: four instances (SAMPLES 4, 300 wrap, 300 sat, 1)
// checked every cycle against a window-level behavioural model.
module tb_sum_accumulator;

  localparam int N = 4;
  localparam int SAMP [N] = '{4, 300, 300, 1};
  localparam bit SATP [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data   [N];
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [7:0] out_data  [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic       out_last  [N];
  logic       out_ovf   [N];

  int errors = 0;
  int checks = 0;

  // Model state: pending output beats {ovf,last,data}, expected in_ready,
  // model-computed results {ovf,total}, and beats actually handed over.
  logic [9:0]  exp_q [N][$];
  logic [16:0] mres  [N][$];
  logic [9:0]  obs   [N][$];
  bit          rdy_exp [N];
  int          rd  [N];
  int          mrd [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sum_accumulator #(.SAMPLES(SAMP[g]), .SAT(SATP[g])) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .out_data (out_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_last (out_last[g]),
      .out_ovf  (out_ovf[g])
    );
  end

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Window-level model: sum accepted bytes, emit two beats when SAMPLES reached.
  initial begin
    int sum [N];
    int cnt [N];
    bit ovf [N];
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          exp_q[i].delete();
          mres[i].delete();
          obs[i].delete();
          sum[i] = 0;
          cnt[i] = 0;
          ovf[i] = 1'b0;
          rdy_exp[i] = 1'b0;
        end else begin
          if (out_valid[i] && out_ready[i])
            obs[i].push_back({out_ovf[i], out_last[i], out_data[i]});
          if (exp_q[i].size() != 0 && out_ready[i])
            void'(exp_q[i].pop_front());
          if (rdy_exp[i] && in_valid[i]) begin
            sum[i] += int'(in_data[i]);
            cnt[i]++;
            if (sum[i] > 65535) begin
              ovf[i] = 1'b1;
              sum[i] = SATP[i] ? 65535 : sum[i] - 65536;
            end
            if (cnt[i] == SAMP[i]) begin
              exp_q[i].push_back({ovf[i], 1'b0, sum[i][7:0]});
              exp_q[i].push_back({ovf[i], 1'b1, sum[i][15:8]});
              mres[i].push_back({ovf[i], sum[i][15:0]});
              sum[i] = 0;
              cnt[i] = 0;
              ovf[i] = 1'b0;
            end
          end
          rdy_exp[i] = (exp_q[i].size() == 0);
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          checkOutput("reset_outs", i, {out_data[i], out_valid[i], out_last[i], out_ovf[i], in_ready[i]}, 0);
        end else begin
          checkOutput("in_ready", i, in_ready[i], rdy_exp[i]);
          checkOutput("out_valid", i, out_valid[i], exp_q[i].size() != 0);
          if (exp_q[i].size() != 0) begin
            checkOutput("out_data", i, out_data[i], exp_q[i][0][7:0]);
            checkOutput("out_last", i, out_last[i], exp_q[i][0][8]);
            checkOutput("out_ovf", i, out_ovf[i], exp_q[i][0][9]);
          end
        end
      end
    end
  end

  // Offers one byte and returns at the negedge after it has been accepted.
  task automatic applyStimulus(input int idx, input logic [7:0] b);
    int n = 0;
    in_data[idx]  = b;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("accept_timeout", idx, 1, 0);
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  // Literal expectation on the next delivered result and on the model itself.
  task automatic expectResult(input int idx, input logic [15:0] res, input logic ovf);
    int n = 0;
    while (obs[idx].size() < rd[idx] + 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (obs[idx].size() < rd[idx] + 2) begin
      checkOutput("result_timeout", idx, 1, 0);
    end else begin
      checkOutput("lo_beat", idx, obs[idx][rd[idx]], {ovf, 1'b0, res[7:0]});
      checkOutput("hi_beat", idx, obs[idx][rd[idx]+1], {ovf, 1'b1, res[15:8]});
      rd[idx] += 2;
    end
    if (mres[idx].size() <= mrd[idx]) begin
      checkOutput("model_missing", idx, 1, 0);
    end else begin
      checkOutput("model_res", idx, mres[idx][mrd[idx]], {ovf, res});
      mrd[idx]++;
    end
  endtask

  task automatic clearReadPointers();
    for (int i = 0; i < N; i++) begin
      rd[i]  = 0;
      mrd[i] = 0;
    end
  endtask

  initial begin
    bit gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] nxt;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data[i]   = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    clearReadPointers();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic window 10,20,30,40");
    applyStimulus(0, 8'h10);
    applyStimulus(0, 8'h20);
    applyStimulus(0, 8'h30);
    applyStimulus(0, 8'h40);
    expectResult(0, 16'h00A0, 1'b0);

    $display("[TB] backpressure in both emit states");
    out_ready[0] = 1'b0;
    applyStimulus(0, 8'h10);
    applyStimulus(0, 8'h20);
    applyStimulus(0, 8'h30);
    applyStimulus(0, 8'h40);
    fork
      applyStimulus(0, 8'h55);
      begin
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b1;
      end
    join
    expectResult(0, 16'h00A0, 1'b0);
    applyStimulus(0, 8'h0B);
    applyStimulus(0, 8'h0A);
    applyStimulus(0, 8'h00);
    expectResult(0, 16'h006A, 1'b0);

    $display("[TB] input gaps");
    nxt = 8'h01;
    for (int k = 0; k < 7; k++) begin
      in_valid[0] = gap_pat[k];
      in_data[0]  = gap_pat[k] ? nxt : 8'hEE;
      if (gap_pat[k]) nxt++;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    expectResult(0, 16'h000A, 1'b0);

    $display("[TB] reset during high beat");
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(0, 8'h33);
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      checkOutput("async_reset", i, {out_data[i], out_valid[i], out_last[i], out_ovf[i], in_ready[i]}, 0);
    clearReadPointers();
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) applyStimulus(0, 8'h01);
    expectResult(0, 16'h0004, 1'b0);

    $display("[TB] SAMPLES=1 back to back");
    fork
      begin
        applyStimulus(3, 8'h7F);
        applyStimulus(3, 8'h80);
      end
      begin
        expectResult(3, 16'h007F, 1'b0);
        expectResult(3, 16'h0080, 1'b0);
      end
    join

    $display("[TB] overflow windows, wrap and saturate");
    for (int k = 0; k < 300; k++)
      fork
        applyStimulus(1, 8'hFF);
        applyStimulus(2, 8'hFF);
      join
    expectResult(1, 16'h2AD4, 1'b1);
    expectResult(2, 16'hFFFF, 1'b1);
    for (int k = 0; k < 300; k++)
      fork
        applyStimulus(1, 8'h01);
        applyStimulus(2, 8'h01);
      join
    expectResult(1, 16'h012C, 1'b0);
    expectResult(2, 16'h012C, 1'b0);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = 1'($urandom_range(0, 1));
        in_data[i]   = 8'($urandom);
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
